pwm_gen: RTL and testbench



---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_gen_edge_rise_det.sv | 25 ++
 rtl/pwm_gen.sv | 100 ++++++++++
 tb/tb_pwm_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the tick-driven PWM generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

   // Default counter / period / duty width.
   localparam int PWM_WIDTH = 8;

   // Counter-width value type at the default width.
   typedef logic [PWM_WIDTH-1:0] pwm_cnt_t;

endpackage

// File: rtl/pwm_gen_edge_rise_det.sv
// One-register rising-edge detector for a divider level output.
// Latency: rise is combinational from d, valid in the cycle d is first seen high.
// Backpressure: none; every rising edge yields exactly one single-cycle pulse.
module edge_rise_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic d_q;

   // Remember the previous level; cleared on reset so a level held high
   // through reset release is reported as one rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d;
      end
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/pwm_gen.sv
// Tick-driven PWM generator: period counter on divider ticks, registered PWM and wrap strobe.
// Latency: cnt updates one edge after tick_rise; pwm_out lags cnt by one clock.
// Backpressure: none. Optional macro PWM_SHADOW_EN defers period/duty changes to the period boundary.
module pwm_gen
   import pwm_pkg::*;
#(
   parameter int WIDTH = PWM_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_in,
   input  logic             en,
   input  logic [WIDTH-1:0] period,
   input  logic [WIDTH-1:0] duty,
   output logic             pwm_out,
   output logic             period_end,
   output logic [WIDTH-1:0] cnt
);

   logic             tick_rise;
   logic [WIDTH-1:0] period_act;
   logic [WIDTH-1:0] duty_act;
   logic             wrap;

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             pe_q, pe_d;
   logic             pwm_q, pwm_d;

   edge_rise_det u_tick_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (tick_in),
      .rise (tick_rise)
   );

   // A counting tick that lands on (or beyond) the last count closes the period.
   assign wrap = en & tick_rise & (cnt_q >= period_act);

`ifdef PWM_SHADOW_EN
   logic [WIDTH-1:0] period_sh_q;
   logic [WIDTH-1:0] duty_sh_q;

   // Shadow copies reload only at a period boundary or while idle, so a
   // running period never sees a half-applied setting.
   always_ff @(posedge clk) begin
      if (rst) begin
         period_sh_q <= '0;
         duty_sh_q   <= '0;
      end else if (!en || wrap) begin
         period_sh_q <= period;
         duty_sh_q   <= duty;
      end
   end

   assign period_act = period_sh_q;
   assign duty_act   = duty_sh_q;
`else
   // Settings act immediately; the >= wrap test keeps a lowered period safe.
   assign period_act = period;
   assign duty_act   = duty;
`endif

   // Next-state for counter, wrap strobe and PWM level.
   always_comb begin
      cnt_d = cnt_q;
      pe_d  = 1'b0;
      pwm_d = 1'b0;
      if (!en) begin
         cnt_d = '0;
      end else begin
         pwm_d = (cnt_q < duty_act);
         if (tick_rise) begin
            if (cnt_q >= period_act) begin
               cnt_d = '0;
               pe_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end
      end
   end

   // State registers; reset overrides enable and ticks.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         pe_q  <= 1'b0;
         pwm_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         pe_q  <= pe_d;
         pwm_q <= pwm_d;
      end
   end

   assign cnt        = cnt_q;
   assign period_end = pe_q;
   assign pwm_out    = pwm_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: per-cycle vector table plus divider-driven sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_gen;
   import pwm_pkg::*;

   localparam int W = PWM_WIDTH;

   logic         clk = 1'b0;
   logic         rst;
   logic         tick_in;
   logic         en;
   logic [W-1:0] period;
   logic [W-1:0] duty;
   logic         pwm_out;
   logic         period_end;
   pwm_cnt_t     cnt;

   int n_cmp = 0;
   int n_bad = 0;
   bit div_on = 1'b0;
   int ph = 0;

   always #5 clk = ~clk;

   pwm_gen #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick_in    (tick_in),
      .en         (en),
      .period     (period),
      .duty       (duty),
      .pwm_out    (pwm_out),
      .period_end (period_end),
      .cnt        (cnt)
   );

   typedef struct {
      logic         rst;
      logic         en;
      logic         tick;
      logic [W-1:0] per;
      logic [W-1:0] dut;
      logic [W-1:0] e_cnt;
      logic         e_pwm;
      logic         e_pe;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input int r, input int e, input int t, input int p, input int d,
                      input int ec, input int ep, input int epe);
      vec_t v;
      v.rst   = 1'(r);
      v.en    = 1'(e);
      v.tick  = 1'(t);
      v.per   = W'(p);
      v.dut   = W'(d);
      v.e_cnt = W'(ec);
      v.e_pwm = 1'(ep);
      v.e_pe  = 1'(epe);
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the rising edge.
   // When enabled, emulate the divide-by-3 divider: one rise every 3 clocks.
   task automatic step();
      @(posedge clk);
      #1;
      if (div_on) begin
         ph = (ph == 2) ? 0 : ph + 1;
         tick_in = (ph == 0);
      end
   endtask

   task automatic wait_cnt(input int v, input int maxc, input string name);
      int k;
      k = 0;
      while (int'(cnt) != v && k < maxc) begin
         step();
         k++;
      end
      if (int'(cnt) != v) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: timeout waiting for cnt=%0d, cnt=%0d", name, v, cnt);
      end
   endtask

   task automatic wait_pe(input int maxc, input string name);
      int k;
      k = 0;
      while (period_end !== 1'b1 && k < maxc) begin
         step();
         k++;
      end
      if (period_end !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: timeout waiting for period_end", name);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pwm_hi;
      int pe_cnt;
      int nz;
      int ev_n;
      int ev[5];
      int exp_ev[5];
      int prev;
      int k;
      int nom_seq[5];

      rst = 1'b1; en = 1'b0; tick_in = 1'b0; period = '0; duty = '0;

      // ---- per-cycle table: {rst,en,tick,period,duty} -> {cnt,pwm,period_end}
      // tick held high through reset release: exactly one count
      add(1,1,1,2,1, 0,0,0);
`ifdef PWM_SHADOW_EN
      // shadow period is 0 out of reset, so the first rise wraps and loads settings
      add(0,1,1,2,1, 0,0,1);
      add(0,1,1,2,1, 0,1,0);
      add(0,1,1,2,1, 0,1,0);
      add(0,1,1,2,1, 0,1,0);
`else
      add(0,1,1,2,1, 1,1,0);
      add(0,1,1,2,1, 1,0,0);
      add(0,1,1,2,1, 1,0,0);
      add(0,1,1,2,1, 1,0,0);
`endif
      // period zero: cnt stays 0, every rise strobes period_end; duty>period -> high
      add(0,0,0,0,1, 0,0,0);
      add(0,1,1,0,1, 0,1,1);
      add(0,1,0,0,1, 0,1,0);
      add(0,1,0,0,1, 0,1,0);
      add(0,1,1,0,1, 0,1,1);
      add(0,1,0,0,1, 0,1,0);
      // duty zero: constant low
      add(0,0,0,4,0, 0,0,0);
      add(0,1,1,4,0, 1,0,0);
      add(0,1,0,4,0, 1,0,0);
      add(0,1,1,4,0, 2,0,0);
      add(0,1,1,4,0, 2,0,0);
      // duty 7 > period 4: constant high, wrap after cnt=4
      add(0,0,0,4,7, 0,0,0);
      add(0,1,1,4,7, 1,1,0);
      add(0,1,0,4,7, 1,1,0);
      add(0,1,1,4,7, 2,1,0);
      add(0,1,0,4,7, 2,1,0);
      add(0,1,1,4,7, 3,1,0);
      add(0,1,0,4,7, 3,1,0);
      add(0,1,1,4,7, 4,1,0);
      add(0,1,0,4,7, 4,1,0);
      add(0,1,1,4,7, 0,1,1);
      add(0,1,0,4,7, 0,1,0);
      // enable low clears immediately
      add(0,0,1,4,7, 0,0,0);

      foreach (tbl[i]) begin
         rst = tbl[i].rst; en = tbl[i].en; tick_in = tbl[i].tick;
         period = tbl[i].per; duty = tbl[i].dut;
         step();
         check($sformatf("vec%0d cnt", i), int'(cnt), int'(tbl[i].e_cnt));
         check($sformatf("vec%0d pwm", i), int'(pwm_out), int'(tbl[i].e_pwm));
         check($sformatf("vec%0d pe", i), int'(period_end), int'(tbl[i].e_pe));
      end

      // ---- nominal waveform with divider: period=4, duty=2
      en = 1'b0; tick_in = 1'b0; period = W'(4); duty = W'(2);
      step(); step();
      ph = 2; div_on = 1'b1; en = 1'b1;
      wait_pe(60, "nom first pe");
      check("nom cnt at pe", int'(cnt), 0);
      nom_seq = '{1, 2, 3, 4, 0};
      pwm_hi = 0; pe_cnt = 0;
      for (int off = 1; off <= 15; off++) begin
         step();
         if (pwm_out) pwm_hi++;
         if (period_end) pe_cnt++;
         if (off % 3 == 0)
            check($sformatf("nom cnt off%0d", off), int'(cnt), nom_seq[off/3 - 1]);
      end
      check("nom pwm high clocks", pwm_hi, 6);
      check("nom pe per 15", pe_cnt, 1);
      check("nom pe at 15", int'(period_end), 1);

      // ---- mid-period change: at cnt=3 lower period to 1
      wait_cnt(3, 30, "mid wait cnt3");
      period = W'(1);
`ifdef PWM_SHADOW_EN
      exp_ev = '{4, 0, 1, 0, 1};
`else
      exp_ev = '{0, 1, 0, 1, 0};
`endif
      prev = int'(cnt); ev_n = 0; k = 0;
      while (ev_n < 5 && k < 40) begin
         step();
         k++;
         if (int'(cnt) != prev || period_end) begin
            ev[ev_n] = int'(cnt);
            ev_n++;
         end
         prev = int'(cnt);
      end
      check("mid event count", ev_n, 5);
      for (int i = 0; i < 5; i++)
         if (i < ev_n) check($sformatf("mid ev%0d", i), ev[i], exp_ev[i]);

      // ---- reset during count at cnt=3 with period=4
      period = W'(4);
      wait_cnt(3, 60, "rst wait cnt3");
      rst = 1'b1;
      step();
      check("rst cnt", int'(cnt), 0);
      check("rst pwm", int'(pwm_out), 0);
      check("rst pe", int'(period_end), 0);
      step();
      rst = 1'b0;

      // ---- enable drop mid-period, then restart from 0
      duty = W'(7);
      wait_cnt(2, 60, "en wait cnt2");
      en = 1'b0;
      step();
      check("endrop cnt", int'(cnt), 0);
      check("endrop pwm", int'(pwm_out), 0);
      check("endrop pe", int'(period_end), 0);
      nz = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (cnt != '0 || pwm_out) nz++;
      end
      check("en low idle", nz, 0);
      en = 1'b1;
      k = 0;
      while (cnt == '0 && k < 30) begin
         step();
         k++;
      end
      check("restart first cnt", int'(cnt), 1);
      check("restart pwm", int'(pwm_out), 1);

      // ---- period zero with divider: strobe every tick (3 clocks)
      en = 1'b0; period = '0; duty = W'(1);
      step();
      en = 1'b1;
      wait_pe(30, "p0 first pe");
      pe_cnt = 0; nz = 0;
      for (int i = 0; i < 9; i++) begin
         step();
         if (period_end) pe_cnt++;
         if (cnt != '0) nz++;
      end
      check("p0 pe per 9 clocks", pe_cnt, 3);
      check("p0 cnt nonzero", nz, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
